// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state encoding and word width for the sequencer and core
package instr_sequencer_pkg;

  localparam int SEQ_DATA_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_store.sv
// rtl/instr_sequencer_prog_store.sv - program register file, sync write, async read
module prog_store #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents survive reset so a reloaded program only overwrites what it writes.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - replays a loaded program into the core and counts its carries
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  input  logic              start,
  input  logic              carry_in,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic              load_full,
  output logic [CNT_W-1:0]  carry_count
);

  localparam logic [ADDR_W:0]  FULL_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] instr_d;
  logic              we_d, busy_d, done_d, full_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              store_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Word 0 is issued on the same edge that accepts start, so IDLE reads address 0.
  assign rd_addr = (state_q == ST_IDLE) ? '0 : rd_ptr_q[ADDR_W-1:0];

  prog_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_store (
    .CLK     (CLK),
    .wr_en   (store_we),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    instr_d  = '0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    cnt_d    = carry_count;
    store_we = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          wr_ptr_d = '0;
        end else if (load_valid) begin
          if (wr_ptr_q != FULL_LEN) begin
            store_we = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end else if (start && (wr_ptr_q != '0)) begin
          state_d  = ST_RUN;
          instr_d  = rd_data;
          we_d     = 1'b1;
          rd_ptr_d = PTR_ONE;
          cnt_d    = '0;
        end
      end

      ST_RUN: begin
        if (carry_in && (carry_count != CNT_MAX)) begin
          cnt_d = carry_count + CNT_ONE;
        end
        if (rd_ptr_q == wr_ptr_q) begin
          state_d = ST_DRAIN;
        end else begin
          instr_d  = rd_data;
          we_d     = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end

      ST_DRAIN: begin
        if (carry_in && (carry_count != CNT_MAX)) begin
          cnt_d = carry_count + CNT_ONE;
        end
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    full_d = (wr_ptr_d == FULL_LEN);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      INSTRUCTION <= '0;
      write_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_full   <= 1'b0;
      carry_count <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      INSTRUCTION <= instr_d;
      write_en    <= we_d;
      busy        <= busy_d;
      done        <= done_d;
      load_full   <= full_d;
      carry_count <= cnt_d;
    end
  end

endmodule
